// File: rtl/mix_stream_tx_pkg.sv
// Shared constants and FSM state type for the mix-stage row-streaming transmitter.
package mix_stream_tx_pkg;

  localparam int unsigned HID_LENGTH  = 24;
  localparam int unsigned BIT_LENGTH  = 16;
  localparam int unsigned ROW_CNT_LEN = 5;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/mix_row_mux.sv
// Combinational selector returning one row (or one column when TRANSPOSE=1)
// of the buffered HID_LENGTH x HID_LENGTH matrix.
module mix_row_mux #(
  parameter int unsigned HID_LENGTH  = mix_stream_tx_pkg::HID_LENGTH,
  parameter int unsigned BIT_LENGTH  = mix_stream_tx_pkg::BIT_LENGTH,
  parameter int unsigned ROW_CNT_LEN = mix_stream_tx_pkg::ROW_CNT_LEN,
  parameter bit          TRANSPOSE   = 1'b0
) (
  input  logic [HID_LENGTH*HID_LENGTH*BIT_LENGTH-1:0] mat_i,
  input  logic [ROW_CNT_LEN-1:0]                      sel_i,
  output logic [HID_LENGTH*BIT_LENGTH-1:0]            row_o
);

  always_comb begin
    row_o = '0;
    for (int unsigned c = 0; c < HID_LENGTH; c++) begin
      // Column mode reads element (c, sel) instead of (sel, c).
      row_o[c*BIT_LENGTH +: BIT_LENGTH] =
        mat_i[(TRANSPOSE ? (HID_LENGTH*c + 32'(sel_i))
                         : (HID_LENGTH*32'(sel_i) + c)) * BIT_LENGTH +: BIT_LENGTH];
    end
  end

endmodule

// File: rtl/mix_stream_tx.sv
// Captures one parallel matrix from the mix layer and streams it out as
// HID_LENGTH valid/ready beats (rows, or columns when TRANSPOSE=1).
module mix_stream_tx #(
  parameter int unsigned HID_LENGTH = mix_stream_tx_pkg::HID_LENGTH,
  parameter int unsigned BIT_LENGTH = mix_stream_tx_pkg::BIT_LENGTH,
  parameter bit          TRANSPOSE  = 1'b0
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        load_valid,
  input  logic [HID_LENGTH*HID_LENGTH*BIT_LENGTH-1:0] data_in,
  output logic                                        load_ready,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [HID_LENGTH*BIT_LENGTH-1:0]            out_data,
  output logic [mix_stream_tx_pkg::ROW_CNT_LEN-1:0]   out_row,
  output logic                                        out_last
);

  import mix_stream_tx_pkg::*;

  localparam logic [ROW_CNT_LEN-1:0] ROW_LAST = ROW_CNT_LEN'(HID_LENGTH - 1);

  tx_state_e                                   state_q;
  logic [ROW_CNT_LEN-1:0]                      row_cnt_q;
  logic [HID_LENGTH*HID_LENGTH*BIT_LENGTH-1:0] buf_q;
  logic [HID_LENGTH*BIT_LENGTH-1:0]            row_sel;

  // rst_n is active-high despite its name; the buffer is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= TX_IDLE;
      row_cnt_q <= '0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (load_valid) begin
            buf_q     <= data_in;
            row_cnt_q <= '0;
            state_q   <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (out_ready) begin
            if (row_cnt_q == ROW_LAST) begin
              row_cnt_q <= '0;
              state_q   <= TX_IDLE;
            end else begin
              row_cnt_q <= row_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q   <= TX_IDLE;
          row_cnt_q <= '0;
        end
      endcase
    end
  end

  mix_row_mux #(
    .HID_LENGTH (HID_LENGTH),
    .BIT_LENGTH (BIT_LENGTH),
    .ROW_CNT_LEN(ROW_CNT_LEN),
    .TRANSPOSE  (TRANSPOSE)
  ) u_row_mux (
    .mat_i(buf_q),
    .sel_i(row_cnt_q),
    .row_o(row_sel)
  );

  // All outputs decode from state registers only; payload is zeroed when idle.
  always_comb begin
    load_ready = (state_q == TX_IDLE);
    out_valid  = (state_q == TX_SEND);
    out_row    = out_valid ? row_cnt_q : '0;
    out_last   = out_valid && (row_cnt_q == ROW_LAST);
    out_data   = out_valid ? row_sel : '0;
  end

endmodule

// File: tb/tb_mix_stream_tx.sv
// Bench for mix_stream_tx: row and column instances driven together, checked
// every cycle against a queue-of-beats model plus a few literal expectations.
module tb_mix_stream_tx;

  localparam int H  = 24;
  localparam int B  = 16;
  localparam int BW = H*B;
  localparam int MW = H*H*B;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          load_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [MW-1:0] data_in = '0;

  logic          lr0, ov0, ol0, lr1, ov1, ol1;
  logic [BW-1:0] od0, od1;
  logic [4:0]    orow0, orow1;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mix_stream_tx #(.HID_LENGTH(H), .BIT_LENGTH(B), .TRANSPOSE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .data_in(data_in),
    .load_ready(lr0), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .out_row(orow0), .out_last(ol0)
  );

  mix_stream_tx #(.HID_LENGTH(H), .BIT_LENGTH(B), .TRANSPOSE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .data_in(data_in),
    .load_ready(lr1), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_row(orow1), .out_last(ol1)
  );

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic logic [BW-1:0] beat(input logic [MW-1:0] m, input int r, input bit tr);
    logic [BW-1:0] b;
    b = '0;
    for (int c = 0; c < H; c++)
      b[c*B +: B] = tr ? m[(H*c + r)*B +: B] : m[(H*r + c)*B +: B];
    return b;
  endfunction

  // Reference: a matrix is a list of beats still owed; the block is idle iff the list is empty.
  logic [BW-1:0] q0[$];
  logic [BW-1:0] q1[$];

  always @(posedge clk) begin
    if (rst_n) begin
      q0.delete();
      q1.delete();
    end else if (q0.size() != 0) begin
      if (out_ready) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
    end else if (load_valid) begin
      for (int r = 0; r < H; r++) begin
        q0.push_back(beat(data_in, r, 1'b0));
        q1.push_back(beat(data_in, r, 1'b1));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit ev;
      int er;
      ev = (q0.size() != 0);
      er = ev ? H - q0.size() : 0;
      chki("m_ready0", int'(lr0), int'(!ev));
      chki("m_valid0", int'(ov0), int'(ev));
      chki("m_row0",   int'(orow0), er);
      chki("m_last0",  int'(ol0), int'(q0.size() == 1));
      chk ("m_data0",  od0, ev ? q0[0] : '0);
      chki("m_ready1", int'(lr1), int'(!ev));
      chki("m_valid1", int'(ov1), int'(ev));
      chki("m_row1",   int'(orow1), er);
      chki("m_last1",  int'(ol1), int'(q1.size() == 1));
      chk ("m_data1",  od1, ev ? q1[0] : '0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int kind);
    for (int i = 0; i < H*H; i++)
      data_in[i*B +: B] = (kind == 0) ? 16'(i) : (kind == 1) ? 16'hFFFF : 16'($urandom);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (!lr0 && n < 200) begin
      step();
      n++;
    end
    chki(nm, int'(lr0), 1);
  endtask

  initial begin
    logic [BW-1:0] expc;
    logic [BW-1:0] prev;
    bit            stalled;
    int            xfer;
    int            last_rise;
    int            lows;
    logic          pv;

    rst_n = 1'b1;
    repeat (3) step();
    chk_en = 1'b1;
    chki("rst_ready", int'(lr0), 1);
    chki("rst_valid", int'(ov0), 0);
    chk ("rst_data",  od0, '0);
    rst_n = 1'b0;
    step();

    // Pattern (r,c)=24r+c, both orientations
    fill(0);
    load_valid = 1'b1;
    out_ready  = 1'b1;
    step();
    load_valid = 1'b0;
    chki("t1_valid_rise", int'(ov0), 1);
    chki("t1_row0", int'(orow0), 0);
    for (int c = 0; c < H; c++) expc[c*B +: B] = 16'(24*c);
    chk("t1_tr_beat0", od1, expc);
    repeat (5) step();
    chki("t1_row5", int'(orow0), 5);
    chki("t1_b5e3", int'(od0[3*B +: B]), 123);
    chki("t1_tr_b5e3", int'(od1[3*B +: B]), 77);
    repeat (18) step();
    chki("t1_row23", int'(orow0), 23);
    chki("t1_last23", int'(ol0), 1);
    step();
    chki("t1_ready_back", int'(lr0), 1);

    // Random stalls
    fill(2);
    load_valid = 1'b1;
    out_ready  = 1'b0;
    step();
    load_valid = 1'b0;
    xfer = 0;
    stalled = 1'b0;
    prev = '0;
    for (int i = 0; i < 400 && !lr0; i++) begin
      if (stalled) chk("t2_stall_hold", od0, prev);
      out_ready = 1'($urandom_range(0, 1));
      if (ov0 && out_ready) begin
        chki("t2_row_seq", int'(orow0), xfer);
        xfer++;
      end
      stalled = ov0 && !out_ready;
      prev = od0;
      step();
    end
    chki("t2_xfers", xfer, 24);

    // Second matrix offered during beat 10
    fill(2);
    load_valid = 1'b1;
    out_ready  = 1'b1;
    step();
    load_valid = 1'b0;
    repeat (10) step();
    chki("t3_row10", int'(orow0), 10);
    fill(1);
    load_valid = 1'b1;
    wait_idle("t3_idle_timeout");
    step();
    load_valid = 1'b0;
    chki("t3_valid", int'(ov0), 1);
    chk ("t3_ffff", od0, '1);
    wait_idle("t3_end_timeout");

    // Reset at beat 7 while stalled
    fill(2);
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    repeat (7) step();
    out_ready = 1'b0;
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    chki("t4_valid", int'(ov0), 0);
    chki("t4_row", int'(orow0), 0);
    chki("t4_ready", int'(lr0), 1);
    fill(2);
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chki("t4_restart_valid", int'(ov0), 1);
    chki("t4_restart_row", int'(orow0), 0);
    out_ready = 1'b1;
    wait_idle("t4_timeout");

    // Reset and load together: reset wins
    rst_n = 1'b1;
    load_valid = 1'b1;
    step();
    rst_n = 1'b0;
    load_valid = 1'b0;
    chki("t4_rst_load", int'(ov0), 0);

    // Back-to-back matrices
    fill(2);
    load_valid = 1'b1;
    out_ready  = 1'b1;
    last_rise = -1;
    lows = 0;
    pv = ov0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      step();
      if (ov0 && !pv) begin
        if (last_rise >= 0) begin
          chki("t5_period", cyc - last_rise, 25);
          chki("t5_low_gap", lows, 1);
        end
        last_rise = cyc;
        lows = 0;
      end
      if (!ov0) lows++;
      pv = ov0;
    end
    load_valid = 1'b0;
    wait_idle("t5_timeout");

    // Random traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      rst_n      = ($urandom_range(0, 59) == 0);
      load_valid = ($urandom_range(0, 2) == 0);
      out_ready  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) fill(2);
      step();
    end
    rst_n = 1'b0;
    load_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle("t6_timeout");
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mix_stream_tx.md
# mix_stream_tx

Row-streaming transmitter for the mix stage. Captures one complete `HID_LENGTH`×`HID_LENGTH` matrix presented in parallel by the mix layer (`data_out`/`valid`) and sends it downstream as `HID_LENGTH` row beats on a valid/ready stream. A compile-time option sends columns instead of rows, so the next layer receives token-major or channel-major order without a separate transposer.

## Interface
- `HID_LENGTH`, 24: matrix dimension (rows, columns, beats per matrix).
- `BIT_LENGTH`, 16: element width, two's complement fixed point, passed through unchanged.
- `TRANSPOSE`, 0: 0 means beat r carries row r; 1 means beat r carries column r.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-high (asserted = 1).
- `load_valid`  in  1  matrix on `data_in` is valid; driven from the mix layer `valid`.
- `data_in`  in  `HID_LENGTH*HID_LENGTH*BIT_LENGTH`  matrix; element (r,c) at `[(HID_LENGTH*r+c)*BIT_LENGTH +: BIT_LENGTH]`.
- `load_ready`  out  1  block can capture a matrix this cycle.
- `out_valid`  out  1  beat on `out_data` is valid.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  `HID_LENGTH*BIT_LENGTH`  beat; element c at `[c*BIT_LENGTH +: BIT_LENGTH]`.
- `out_row`  out  `ROW_CNT_LEN` (5)  index of the current beat, 0..`HID_LENGTH`-1.
- `out_last`  out  1  high with `out_valid` on beat `HID_LENGTH`-1.

## Operation
- FSM states are IDLE and SEND.
- IDLE:
  - `load_ready`=1, `out_valid`=0.
  - If `load_valid`=1, register all of `data_in` into the matrix buffer, set `row_cnt`=0, go to SEND.
- SEND:
  - `load_ready`=0, `out_valid`=1.
  - `out_data` is the row (or column, if `TRANSPOSE`=1) selected by `row_cnt`, read from the buffer.
  - `out_row`=`row_cnt`; `out_last`=(`row_cnt`==`HID_LENGTH`-1).
- Handshake: a beat transfers in a cycle where `out_valid` and `out_ready` are both 1.
  - On a transfer with `row_cnt`<`HID_LENGTH`-1: increment `row_cnt`.
  - On a transfer with `row_cnt`==`HID_LENGTH`-1: go to IDLE and clear `row_cnt` to 0.
- Stall: while `out_ready`=0, `out_data`, `out_row` and `out_last` hold exactly. `out_valid` never drops before its transfer.
- TRANSPOSE=1: element c of beat r = `data_in` element (c,r), i.e. `[(HID_LENGTH*c+r)*BIT_LENGTH +: BIT_LENGTH]` of the captured matrix.
- `load_valid` during SEND is ignored. No capture, no corruption of the buffer; the upstream matrix is lost unless it holds `valid`. The mix layer keeps `valid` high until the next `run`, so a hold is guaranteed.
- `out_data`, `out_row` and `out_last` are forced to 0 whenever `out_valid`=0.
- No arithmetic is performed. Width of `row_cnt` = `ROW_CNT_LEN`; the wrap at `HID_LENGTH`-1 is explicit, never a natural overflow.

## Timing
- Reset (`rst_n`=1 at an edge):
  - State becomes IDLE and `row_cnt`=0.
  - Outputs are `load_ready`=1 after reset releases, and `out_valid`=0, `out_data`=0, `out_row`=0, `out_last`=0.
  - The buffer is not reset.
- Reset mid-matrix aborts the stream at once. The next cycle shows `out_valid`=0, and the partial matrix is discarded.
- Latency: capture at edge N, so `out_valid`=1 with row 0 in cycle N+1.
- Throughput: with `out_ready` held at 1, one matrix takes `HID_LENGTH` beats plus 1 IDLE cycle, i.e. 25 cycles per matrix.
- Simultaneous events:
  - Last-beat transfer and `load_valid` in the same cycle: the load is not taken (`load_ready`=0). It is taken in the following IDLE cycle.
  - `load_valid` and reset in the same cycle: reset wins and no capture happens.
- All outputs are registered or decoded from registers only. There is no combinational path from `out_ready` or `load_valid` to any output.

## Structure
- Constants live in `num_data.v`: `HID_LENGTH`, `BIT_LENGTH`, plus a new `` `ROW_CNT_LEN `` (5). No duplicated literals in the module.
- FSM state encodings (`` `TX_IDLE ``, `` `TX_SEND ``) are defined in `num_data.v` next to `STATE_LEN`.
- One sub-module, `mix_row_mux`: a combinational selector taking the buffer, `row_cnt` and `TRANSPOSE`, and returning one row or column. The FSM, counter and buffer stay in `mix_stream_tx`.

## Test plan
- Reset, then one load of element (r,c)=`16'(24r+c)` with `out_ready`=1 and `TRANSPOSE`=0:
  - `out_valid` rises the cycle after the load.
  - 24 consecutive beats arrive; beat 5 element 3 = 123.
  - `out_last` is high only on beat 23.
  - `load_ready` returns the next cycle.
- Same matrix with `TRANSPOSE`=1: beat 5 element 3 = 77 (element (3,5)); beat 0 = {0,24,...,552}.
- Random `out_ready` stalls (about 50%):
  - `out_data` and `out_row` stable across every stall.
  - Exactly 24 transfers, with `out_row` running 0..23 and no skips or repeats.
- Second matrix (all 16'hFFFF) on `load_valid` during beat 10:
  - First stream is unaffected.
  - Capture happens in the IDLE cycle after beat 23, and the next stream is all 16'hFFFF.
- Reset asserted at beat 7 while `out_ready`=0:
  - Next cycle `out_valid`=0, `out_row`=0, `load_ready`=1.
  - A fresh load restarts at row 0.
- Back-to-back loads with `out_ready`=1 and `load_valid` held high: `out_valid` has a period of 25 cycles with exactly one low cycle between matrices.
